// File: rtl/accum_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : accum_sequencer
// Brief    : Command sequencer that drives add/increment strobes into a W-bit
//            accumulator, repeating a single-cycle op up to 2^CW-1 times.
// Revision : 1.0 - initial release
// ============================================================================
module accum_sequencer #(
    parameter int W  = 4,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [W-1:0]  cmd_val,
    input  logic [CW-1:0] cmd_cnt,
    input  logic          stall,
    output logic          s1,
    output logic          s2,
    output logic [W-1:0]  r2,
    output logic          busy,
    output logic          done
);

    localparam logic [CW-1:0] c_ZERO = '0;
    localparam logic [CW-1:0] c_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_rem;
    logic [CW-1:0] w_rem_nxt;
    logic [1:0]    r_op;
    logic [W-1:0]  r_val;

    logic          w_accept;
    logic          w_issue;
    logic [CW-1:0] w_accept_cnt;

    assign w_accept     = (r_state == ST_IDLE) && cmd_valid;
    // Strobes are gated by rst directly so a reset mid-run silences them
    // in the same cycle rather than one edge later.
    assign w_issue      = (r_state == ST_RUN) && !stall && !rst;
    // Single ops (op[1]=0) always run once; repeated ops take the count.
    assign w_accept_cnt = cmd_op[1] ? cmd_cnt : c_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_rem_nxt   = w_accept_cnt;
                    w_state_nxt = (w_accept_cnt != c_ZERO) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (w_issue) begin
                    w_rem_nxt = r_rem - c_ONE;
                    if (r_rem == c_ONE) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_rem_nxt   = c_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rem   <= c_ZERO;
            r_op    <= 2'b00;
            r_val   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            if (w_accept) begin
                r_op  <= cmd_op;
                r_val <= cmd_val;
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign done      = (r_state == ST_DONE);
    assign s1        = w_issue &  r_op[0];
    assign s2        = w_issue & ~r_op[0];
    assign r2        = (r_state != ST_IDLE) ? r_val : '0;

endmodule
`default_nettype wire
